// File: rtl/odd_even_down_counter.sv
// Loadable step-by-2 down-counter over the odd or even sequence, clamped at floor 1 (odd) / 0 (even).
// Optional auto-reload after each done pulse when ODD_EVEN_DOWN_RELOAD_EN is defined.
module odd_even_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             odd_even,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // state | meaning
    // IDLE  | no countdown active; count holds its last value, enable ignored
    // COUNT | stepping by -2 on each enable until the floor is reached
    // DONE  | one-cycle completion pulse; count sits at the floor
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_d;
    logic             err_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] floor_val;
    logic [WIDTH-1:0] load_forced;

    assign floor_val   = {{(WIDTH-1){1'b0}}, mode_q};
    assign load_forced = {load_val[WIDTH-1:1], odd_even};

`ifdef ODD_EVEN_DOWN_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count    <= '0;
            err      <= 1'b0;
            mode_q   <= 1'b0;
`ifdef ODD_EVEN_DOWN_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            err      <= err_d;
            mode_q   <= mode_d;
`ifdef ODD_EVEN_DOWN_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count;
        err_d    = err;
        mode_d   = mode_q;
`ifdef ODD_EVEN_DOWN_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            count_d  = load_forced;
            err_d    = load_val[0] ^ odd_even;
            mode_d   = odd_even;
            state_d  = COUNT;
`ifdef ODD_EVEN_DOWN_RELOAD_EN
            reload_d = load_forced;
`endif
        end else begin
            case (state_q)
                COUNT: begin
                    // Clamp to the floor instead of subtracting so the count never wraps.
                    if (enable) begin
                        if (count <= floor_val + TWO) begin
                            count_d = floor_val;
                            state_d = DONE;
                        end else begin
                            count_d = count - TWO;
                        end
                    end
                end
                DONE: begin
`ifdef ODD_EVEN_DOWN_RELOAD_EN
                    count_d = reload_q;
                    state_d = COUNT;
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q == COUNT);
    assign done = (state_q == DONE);

endmodule
